// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: accepts one load/store miss at a time, reads the
// whole block from next-level memory as 32-bit beats, writes it into the cache
// as a single repair write, replays a store word, then reports completion.
// Every cache-side output is decoded from the FSM state and captured registers,
// so no memory input reaches the cache port in the same cycle.

// One 32-bit word of the refill buffer; loads its beat when its strobe fires.
module dcache_refill_beat_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [31:0] i_data,
  output logic [31:0] o_word
);

  logic [31:0] r_word;

  // Capture the beat addressed to this slot; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_word <= '0;
    else if (i_we) r_word <= i_data;
  end

  assign o_word = r_word;

endmodule

module dcache_refill_ctrl #(
  parameter int BLOCK_SIZE = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // miss request from the pipeline
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_addr_i,
  input  logic                  miss_is_store_i,
  input  logic [31:0]           miss_wdata_i,
  input  logic                  abort_i,
  // next-level memory
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [31:0]           mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [31:0]           mem_resp_data_i,
  // cache repair/write port
  output logic                  cache_w_en_o,
  output logic                  cache_is_repair_o,
  output logic [31:0]           cache_w_addr_o,
  output logic [31:0]           cache_w_data_o,
  output logic [BLOCK_SIZE-1:0] cache_repair_data_o,
  // completion
  output logic                  done_o,
  output logic [31:0]           done_data_o
);

  localparam int BEATS    = BLOCK_SIZE / 32;
  localparam int OFF_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_DRAIN,
    S_REPAIR,
    S_REPLAY,
    S_DONE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_beat_cnt, w_beat_cnt_nxt;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic                    r_is_store;

  logic                    w_cnt_last;
  logic                    w_fill_we;
  logic [BEATS-1:0]        w_slot_we;
  logic [BEATS-1:0][31:0]  w_buf;

  assign w_cnt_last = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_fill_we  = (r_state == S_FILL) && mem_resp_valid_i;

  // Block buffer: one slot per beat, strobed by the beat counter.
  for (genvar g = 0; g < BEATS; g++) begin : g_slot
    assign w_slot_we[g] = w_fill_we && (r_beat_cnt == CNT_W'(g));

    dcache_refill_beat_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   (w_slot_we[g]),
      .i_data (mem_resp_data_i),
      .o_word (w_buf[g])
    );
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Miss capture: address, kind and store data are latched on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_store <= 1'b0;
    end else if (r_state == S_IDLE && miss_valid_i) begin
      r_addr     <= miss_addr_i;
      r_wdata    <= miss_wdata_i;
      r_is_store <= miss_is_store_i;
    end
  end

  // Next-state and beat-count logic. Beats in flight after an abort are
  // still counted so the memory stream is fully consumed before the next miss.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (miss_valid_i) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready_i) begin
          // request is issued even when aborted in the same cycle
          w_beat_cnt_nxt = '0;
          w_state_nxt    = abort_i ? S_DRAIN : S_FILL;
        end else if (abort_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (mem_resp_valid_i) begin
          if (w_cnt_last) begin
            w_beat_cnt_nxt = '0;
            // abort on the final beat leaves nothing to drain
            w_state_nxt    = abort_i ? S_IDLE : S_REPAIR;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            if (abort_i) w_state_nxt = S_DRAIN;
          end
        end else if (abort_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_resp_valid_i) begin
          if (w_cnt_last) begin
            w_beat_cnt_nxt = '0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      S_REPAIR: w_state_nxt = r_is_store ? S_REPLAY : S_DONE;
      S_REPLAY: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: state selects, captured registers supply the data.
  always_comb begin
    miss_ready_o        = (r_state == S_IDLE);
    mem_req_valid_o     = (r_state == S_REQ);
    mem_req_addr_o      = '0;
    cache_w_en_o        = (r_state == S_REPAIR) || (r_state == S_REPLAY);
    cache_is_repair_o   = (r_state == S_REPAIR);
    cache_w_addr_o      = '0;
    cache_w_data_o      = '0;
    cache_repair_data_o = '0;
    done_o              = (r_state == S_DONE);
    done_data_o         = '0;
    if (r_state == S_REQ)
      mem_req_addr_o = {r_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
    if (cache_w_en_o)
      cache_w_addr_o = r_addr;
    if (r_state == S_REPAIR)
      cache_repair_data_o = w_buf;
    if (r_state == S_REPLAY)
      cache_w_data_o = r_wdata;
    // for a store this is the pre-store word, since the buffer is never patched
    if (r_state == S_DONE)
      done_data_o = w_buf[r_addr[OFF_BITS-1:2]];
  end

endmodule
